// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared types and constants for the seven-segment scan controller.
//   scan_state_t   : scan FSM states (BLANK guard period, DRIVE one digit)
//   DEFAULT_DWELL  : default clk cycles a digit is driven
//   DEFAULT_GUARD  : default clk cycles of all-off before each digit
//   HEX_W          : width of one stored hex digit
// ---------------------------------------------------------------------------
package seg7_pkg;

   typedef enum logic {
      BLANK = 1'b0,
      DRIVE = 1'b1
   } scan_state_t;

   localparam int DEFAULT_DWELL = 2500;
   localparam int DEFAULT_GUARD = 16;
   localparam int HEX_W         = 4;

endpackage

// File: rtl/seg7_scan_ctrl_decoder.sv
// ---------------------------------------------------------------------------
// seg7_scan_ctrl_decoder
// Hex digit to seven-segment pattern decoder, active-high segments.
// Bit order is {g,f,e,d,c,b,a}; segment a is bit 0.
// Ports:
//   digit     in   HEX_W  hex value to display
//   segments  out  7      segment pattern for that value
// ---------------------------------------------------------------------------
module seg7_scan_ctrl_decoder
   import seg7_pkg::*;
(
   input  logic [HEX_W-1:0] digit,
   output logic [6:0]       segments
);

   // Pure lookup; lower-case glyphs are used for b and d so they stay
   // distinguishable from 8 and 0.
   always_comb begin
      segments = 7'h00;
      case (digit)
         4'h0: segments = 7'h3F;
         4'h1: segments = 7'h06;
         4'h2: segments = 7'h5B;
         4'h3: segments = 7'h4F;
         4'h4: segments = 7'h66;
         4'h5: segments = 7'h6D;
         4'h6: segments = 7'h7D;
         4'h7: segments = 7'h07;
         4'h8: segments = 7'h7F;
         4'h9: segments = 7'h6F;
         4'hA: segments = 7'h77;
         4'hB: segments = 7'h7C;
         4'hC: segments = 7'h39;
         4'hD: segments = 7'h5E;
         4'hE: segments = 7'h79;
         4'hF: segments = 7'h71;
         default: segments = 7'h00;
      endcase
   end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg7_scan_ctrl
// Time-multiplexed scan controller for an NDIG-digit common-segment display.
// A shadow bank is written over a valid/ready port; a commit publishes the
// whole shadow bank into the displayed (active) bank at the next frame end,
// so a frame never shows a mix of old and new digits. Each digit is preceded
// by a guard period with every digit off to suppress ghosting.
// Ports:
//   clk         in   1            clock
//   rst_n       in   1            synchronous active-low reset
//   en          in   1            scan enable; 0 parks the scan, display dark
//   wr_valid    in   1            write request
//   wr_ready    out  1            write accept (low while a commit is pending)
//   wr_addr     in   clog2(NDIG)  digit index; indices >= NDIG are discarded
//   wr_data     in   4            hex value for that digit
//   commit      in   1            publish shadow bank at next frame end
//   seg_out     out  7            segment drive for the active digit
//   dig_en      out  NDIG         one-hot digit enable, active high
//   frame_tick  out  1            high for the last cycle of each frame
// ---------------------------------------------------------------------------
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int NDIG  = 4,
   parameter int DWELL = DEFAULT_DWELL,
   parameter int GUARD = DEFAULT_GUARD,
   parameter int CNT_W = 12
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    wr_valid,
   output logic                    wr_ready,
   input  logic [$clog2(NDIG)-1:0] wr_addr,
   input  logic [HEX_W-1:0]        wr_data,
   input  logic                    commit,
   output logic [6:0]              seg_out,
   output logic [NDIG-1:0]         dig_en,
   output logic                    frame_tick
);

   localparam int AW = $clog2(NDIG);

   scan_state_t      state;
   logic [CNT_W-1:0] cnt;
   logic [AW-1:0]    idx;
   logic             pending;
   logic [HEX_W-1:0] shadow [NDIG];
   logic [HEX_W-1:0] active [NDIG];
   logic [6:0]       dec_seg;

   logic last_guard;
   logic last_dwell;
   logic last_digit;
   logic wr_fire;
   logic addr_ok;

   assign last_guard = (cnt == CNT_W'(GUARD - 1));
   assign last_dwell = (cnt == CNT_W'(DWELL - 1));
   assign last_digit = (idx == AW'(NDIG - 1));
   assign wr_fire    = wr_valid && wr_ready;
   assign addr_ok    = (int'(wr_addr) < NDIG);

   // The frame ends on the last dwell cycle of the last digit. The en term
   // keeps a publish from happening on the very edge that parks the scan.
   assign frame_tick = (state == DRIVE) && last_digit && last_dwell && en;

   // Writes are held off while a commit is waiting, so the shadow bank being
   // published can never change underneath the publish.
   assign wr_ready = !pending;

   // Scan sequencer: BLANK counts the guard period, DRIVE counts the dwell of
   // digit idx, then idx advances and the next guard starts. Dropping en parks
   // the scan at the start of the guard before digit 0.
   always_ff @(posedge clk) begin
      if (!rst_n || !en) begin
         state <= BLANK;
         cnt   <= '0;
         idx   <= '0;
      end else begin
         case (state)
            BLANK: begin
               if (last_guard) begin
                  cnt   <= '0;
                  state <= DRIVE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            DRIVE: begin
               if (last_dwell) begin
                  cnt   <= '0;
                  idx   <= last_digit ? '0 : idx + AW'(1);
                  state <= BLANK;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               cnt   <= '0;
               idx   <= '0;
               state <= BLANK;
            end
         endcase
      end
   end

   // Double-buffered digit banks and the commit handshake. A write and a
   // commit in the same cycle both land on one edge, so the write is part of
   // that commit. A commit that arrives on the frame_tick cycle with nothing
   // pending only arms pending; the publish waits for the following frame end.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NDIG; i++) begin
            shadow[i] <= '0;
            active[i] <= '0;
         end
         pending <= 1'b0;
      end else begin
         if (wr_fire && addr_ok) begin
            shadow[wr_addr] <= wr_data;
         end
         if (frame_tick && pending) begin
            for (int i = 0; i < NDIG; i++) begin
               active[i] <= shadow[i];
            end
            pending <= 1'b0;
         end else if (commit && !pending) begin
            pending <= 1'b1;
         end
      end
   end

   // One shared decoder follows the scan index; its output is masked during
   // the guard period so no segment is lit while the digit select changes.
   seg7_scan_ctrl_decoder u_dec (
      .digit    (active[idx]),
      .segments (dec_seg)
   );

   assign seg_out = (state == DRIVE) ? dec_seg : 7'h00;
   assign dig_en  = (state == DRIVE) ? (NDIG'(1) << idx) : '0;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_ctrl
// Directed self-checking bench for seg7_scan_ctrl with NDIG=4, DWELL=4,
// GUARD=2 (24-cycle frame). Inputs change 1 time unit after each rising edge
// and outputs are sampled at that same point, i.e. away from the edge.
// ---------------------------------------------------------------------------
module tb_seg7_scan_ctrl;

   localparam int NDIG  = 4;
   localparam int DWELL = 4;
   localparam int GUARD = 2;
   localparam int CNT_W = 12;
   localparam int SLOT  = GUARD + DWELL;
   localparam int FRAME = NDIG * SLOT;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic       wr_valid;
   logic       wr_ready;
   logic [1:0] wr_addr;
   logic [3:0] wr_data;
   logic       commit;
   logic [6:0] seg_out;
   logic [3:0] dig_en;
   logic       frame_tick;

   int errors = 0;
   int checks = 0;
   int pos    = 0;
   logic [3:0] shown [NDIG];

   seg7_scan_ctrl #(
      .NDIG  (NDIG),
      .DWELL (DWELL),
      .GUARD (GUARD),
      .CNT_W (CNT_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .commit     (commit),
      .seg_out    (seg_out),
      .dig_en     (dig_en),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   // Hand-written segment reference, {g,f,e,d,c,b,a}.
   function automatic logic [6:0] seg7_ref(input logic [3:0] h);
      case (h)
         4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;
         4'h3: return 7'h4F;  4'h4: return 7'h66;  4'h5: return 7'h6D;
         4'h6: return 7'h7D;  4'h7: return 7'h07;  4'h8: return 7'h7F;
         4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
         4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;
         default: return 7'h71;
      endcase
   endfunction

   // Expected digit enable at frame position p: guard cycles first, then dwell.
   function automatic logic [3:0] exp_dig(input int p);
      if ((p % SLOT) < GUARD) return 4'b0000;
      return 4'(1 << (p / SLOT));
   endfunction

   function automatic logic [6:0] exp_seg(input int p);
      if ((p % SLOT) < GUARD) return 7'h00;
      return seg7_ref(shown[p / SLOT]);
   endfunction

   // One clock; the frame position restarts whenever reset or !en was seen.
   task automatic step();
      logic en_s;
      logic rst_s;
      en_s  = en;
      rst_s = rst_n;
      @(posedge clk);
      #1;
      if (!rst_s || !en_s) pos = 0;
      else pos = (pos + 1) % FRAME;
   endtask

   task automatic advance_to(input int p);
      for (int k = 0; k < 2 * FRAME && pos != p; k++) step();
      checks++;
      if (pos != p) begin
         errors++;
         $display("[TB] FAIL advance_to: position %0d, wanted %0d", pos, p);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b1; wr_valid = 1'b0; commit = 1'b0;
      wr_addr = 2'd0; wr_data = 4'h0;
      for (int i = 0; i < NDIG; i++) shown[i] = 4'h0;
      step(); step();
      checks++;
      if (dig_en !== 4'b0000) begin errors++; $display("[TB] FAIL reset_dig_en: got %b expected 0000", dig_en); end
      checks++;
      if (seg_out !== 7'h00) begin errors++; $display("[TB] FAIL reset_seg_out: got %h expected 00", seg_out); end
      checks++;
      if (frame_tick !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_tick: got %b expected 0", frame_tick); end
      checks++;
      if (wr_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_wr_ready: got %b expected 1", wr_ready); end
      rst_n = 1'b1;
   endtask

   task automatic test_scan();
      for (int c = 0; c < 2 * FRAME; c++) begin
         checks++;
         if ({dig_en, seg_out, frame_tick} !== {exp_dig(pos), exp_seg(pos), pos == FRAME - 1}) begin
            errors++;
            $display("[TB] FAIL scan_pos%0d: got dig=%b seg=%h tick=%b expected dig=%b seg=%h tick=%b",
                     pos, dig_en, seg_out, frame_tick, exp_dig(pos), exp_seg(pos), pos == FRAME - 1);
         end
         step();
      end
   endtask

   task automatic test_write_commit();
      advance_to(8);
      wr_valid = 1'b1; wr_addr = 2'd2; wr_data = 4'hA; commit = 1'b1;
      checks++;
      if (wr_ready !== 1'b1) begin errors++; $display("[TB] FAIL wc_ready_before: got %b expected 1", wr_ready); end
      step();
      wr_valid = 1'b0; commit = 1'b0;
      for (int k = 0; k < 2 * FRAME && pos != 0; k++) begin
         checks++;
         if (wr_ready !== 1'b0) begin errors++; $display("[TB] FAIL wc_ready_pending_pos%0d: got %b expected 0", pos, wr_ready); end
         if (pos >= 14 && pos <= 17) begin
            checks++;
            if ({dig_en, seg_out} !== {4'b0100, seg7_ref(4'h0)}) begin
               errors++;
               $display("[TB] FAIL wc_old_digit2_pos%0d: got dig=%b seg=%h expected dig=0100 seg=%h", pos, dig_en, seg_out, seg7_ref(4'h0));
            end
         end
         if (pos == FRAME - 1) begin
            checks++;
            if (frame_tick !== 1'b1) begin errors++; $display("[TB] FAIL wc_tick: got %b expected 1", frame_tick); end
         end
         step();
      end
      checks++;
      if (wr_ready !== 1'b1) begin errors++; $display("[TB] FAIL wc_ready_after: got %b expected 1", wr_ready); end
      shown[2] = 4'hA;
      advance_to(15);
      checks++;
      if ({dig_en, seg_out} !== {4'b0100, 7'h77}) begin
         errors++;
         $display("[TB] FAIL wc_new_digit2: got dig=%b seg=%h expected dig=0100 seg=77", dig_en, seg_out);
      end
   endtask

   task automatic test_stalled_write();
      int stall;
      int accept_pos;
      stall = 0; accept_pos = -1;
      advance_to(18);
      commit = 1'b1;
      step();
      commit = 1'b0;
      wr_valid = 1'b1; wr_addr = 2'd1; wr_data = 4'h5;
      for (int k = 0; k < 2 * FRAME; k++) begin
         if (wr_ready) begin
            accept_pos = pos;
            step();
            wr_valid = 1'b0;
            break;
         end
         stall++;
         step();
      end
      checks++;
      if (accept_pos !== 0) begin errors++; $display("[TB] FAIL stall_accept_pos: got %0d expected 0", accept_pos); end
      checks++;
      if (stall !== 5) begin errors++; $display("[TB] FAIL stall_cycles: got %0d expected 5", stall); end
      checks++;
      if (wr_ready !== 1'b1) begin errors++; $display("[TB] FAIL stall_ready_after_write: got %b expected 1", wr_ready); end
      commit = 1'b1;
      step();
      commit = 1'b0;
      checks++;
      if (wr_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall_ready_commit2: got %b expected 0", wr_ready); end
      advance_to(9);
      checks++;
      if ({dig_en, seg_out} !== {4'b0010, 7'h3F}) begin
         errors++;
         $display("[TB] FAIL stall_old_digit1: got dig=%b seg=%h expected dig=0010 seg=3f", dig_en, seg_out);
      end
      advance_to(0);
      shown[1] = 4'h5;
      advance_to(9);
      checks++;
      if ({dig_en, seg_out} !== {4'b0010, 7'h6D}) begin
         errors++;
         $display("[TB] FAIL stall_new_digit1: got dig=%b seg=%h expected dig=0010 seg=6d", dig_en, seg_out);
      end
   endtask

   task automatic test_enable_drop();
      advance_to(10);
      en = 1'b0;
      step();
      checks++;
      if ({dig_en, seg_out, frame_tick} !== {4'b0000, 7'h00, 1'b0}) begin
         errors++;
         $display("[TB] FAIL en_dark: got dig=%b seg=%h tick=%b expected dig=0000 seg=00 tick=0", dig_en, seg_out, frame_tick);
      end
      step(); step();
      checks++;
      if (dig_en !== 4'b0000) begin errors++; $display("[TB] FAIL en_held_dark: got %b expected 0000", dig_en); end
      en = 1'b1;
      for (int c = 0; c < 8; c++) begin
         checks++;
         if ({dig_en, seg_out} !== {exp_dig(c), exp_seg(c)}) begin
            errors++;
            $display("[TB] FAIL en_restart_c%0d: got dig=%b seg=%h expected dig=%b seg=%h", c, dig_en, seg_out, exp_dig(c), exp_seg(c));
         end
         step();
      end
      advance_to(15);
      checks++;
      if (seg_out !== 7'h77) begin errors++; $display("[TB] FAIL en_bank_kept: got %h expected 77", seg_out); end
   endtask

   task automatic test_commit_at_tick();
      advance_to(2);
      wr_valid = 1'b1; wr_addr = 2'd3; wr_data = 4'h7;
      step();
      wr_valid = 1'b0;
      checks++;
      if (wr_ready !== 1'b1) begin errors++; $display("[TB] FAIL cat_no_pending: got %b expected 1", wr_ready); end
      advance_to(FRAME - 1);
      checks++;
      if (frame_tick !== 1'b1) begin errors++; $display("[TB] FAIL cat_tick: got %b expected 1", frame_tick); end
      commit = 1'b1;
      step();
      commit = 1'b0;
      checks++;
      if (wr_ready !== 1'b0) begin errors++; $display("[TB] FAIL cat_pending_set: got %b expected 0", wr_ready); end
      advance_to(21);
      checks++;
      if ({dig_en, seg_out} !== {4'b1000, 7'h3F}) begin
         errors++;
         $display("[TB] FAIL cat_not_yet: got dig=%b seg=%h expected dig=1000 seg=3f", dig_en, seg_out);
      end
      advance_to(0);
      checks++;
      if (wr_ready !== 1'b1) begin errors++; $display("[TB] FAIL cat_published: got %b expected 1", wr_ready); end
      shown[3] = 4'h7;
      advance_to(21);
      checks++;
      if ({dig_en, seg_out} !== {4'b1000, 7'h07}) begin
         errors++;
         $display("[TB] FAIL cat_new_digit3: got dig=%b seg=%h expected dig=1000 seg=07", dig_en, seg_out);
      end
   endtask

   task automatic test_reset_mid();
      advance_to(8);
      wr_valid = 1'b1; wr_addr = 2'd0; wr_data = 4'h9; commit = 1'b1;
      step();
      wr_valid = 1'b0; commit = 1'b0;
      checks++;
      if (wr_ready !== 1'b0) begin errors++; $display("[TB] FAIL rm_pending: got %b expected 0", wr_ready); end
      advance_to(16);
      rst_n = 1'b0;
      step();
      checks++;
      if ({dig_en, seg_out, frame_tick, wr_ready} !== {4'b0000, 7'h00, 1'b0, 1'b1}) begin
         errors++;
         $display("[TB] FAIL rm_outputs: got dig=%b seg=%h tick=%b rdy=%b expected dig=0000 seg=00 tick=0 rdy=1",
                  dig_en, seg_out, frame_tick, wr_ready);
      end
      rst_n = 1'b1;
      for (int i = 0; i < NDIG; i++) shown[i] = 4'h0;
      for (int c = 0; c < 2 * FRAME; c++) begin
         checks++;
         if ({dig_en, seg_out, frame_tick, wr_ready} !== {exp_dig(pos), exp_seg(pos), pos == FRAME - 1, 1'b1}) begin
            errors++;
            $display("[TB] FAIL rm_scan_pos%0d: got dig=%b seg=%h tick=%b rdy=%b expected dig=%b seg=%h tick=%b rdy=1",
                     pos, dig_en, seg_out, frame_tick, wr_ready, exp_dig(pos), exp_seg(pos), pos == FRAME - 1);
         end
         step();
      end
   endtask

   initial begin
      test_reset();
      test_scan();
      test_write_commit();
      test_stalled_write();
      test_enable_drop();
      test_commit_at_tick();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
